// File: rtl/ray_march_ctrl_pkg.sv
// Shared definitions for the sphere-tracing controller.
// The float27 layout is: bit 26 sign, bits 25:18 exponent (bias 127) and bits 17:0 mantissa.
// Denormals are flushed to zero, so an exponent of 0 always means the value is zero.
package ray_march_ctrl_pkg;

  localparam int unsigned FLT_W    = 27;
  localparam int unsigned SIGN_BIT = 26;
  localparam int unsigned EXP_MSB  = 25;
  localparam int unsigned EXP_LSB  = 18;
  localparam int unsigned MANT_W   = 18;

  localparam logic [FLT_W-1:0] ONE      = 27'h1fc0000;
  localparam logic [FLT_W-1:0] NEG_ONE  = 27'h5fc0000;
  localparam logic [FLT_W-1:0] TWO      = 27'h2000000;
  localparam logic [FLT_W-1:0] HIT_EPS  = 27'h1e00000;
  localparam logic [FLT_W-1:0] MAX_DIST = 27'h2200000;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StStep,
    StDone
  } state_e;

  typedef struct packed {
    logic [FLT_W-1:0] x;
    logic [FLT_W-1:0] y;
    logic [FLT_W-1:0] z;
  } vec3_t;

  // |a| < |b|. The sign is ignored and a zero exponent is treated as zero magnitude.
  function automatic logic float_lt_mag(input logic [FLT_W-1:0] a, input logic [FLT_W-1:0] b);
    logic [EXP_MSB:0] mag_a;
    logic [EXP_MSB:0] mag_b;
    mag_a = (a[EXP_MSB:EXP_LSB] == '0) ? '0 : a[EXP_MSB:0];
    mag_b = (b[EXP_MSB:EXP_LSB] == '0) ? '0 : b[EXP_MSB:0];
    return mag_a < mag_b;
  endfunction

endpackage

// File: rtl/ray_march_ctrl_step.sv
// ray_step: pipelined three-lane fused step, point' = point + dir * d and t' = t + d.
// The pipeline has a fixed latency of STEP_LATENCY cycles from in_valid to out_valid and never stalls.
// Stage A registers the dir * d products. The adds are then registered, and the result is delayed to fill the latency.
// Ports:
//   clk, reset          clock and synchronous active-high reset (clears the valid bits only)
//   in_valid            launch a step
//   in_p*, in_d*        current point and direction
//   in_d, in_t          sampled distance and accumulated t
//   out_valid           result valid (one-cycle pulse)
//   out_p*, out_t       advanced point and t
module ray_step
  import ray_march_ctrl_pkg::*;
#(
  parameter int unsigned STEP_LATENCY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [26:0]   in_px,
  input  logic [26:0]   in_py,
  input  logic [26:0]   in_pz,
  input  logic [26:0]   in_dx,
  input  logic [26:0]   in_dy,
  input  logic [26:0]   in_dz,
  input  logic [26:0]   in_d,
  input  logic [26:0]   in_t,
  output logic          out_valid,
  output logic [26:0]   out_px,
  output logic [26:0]   out_py,
  output logic [26:0]   out_pz,
  output logic [26:0]   out_t
);

  localparam int unsigned Depth = STEP_LATENCY - 1;

  // Truncating float27 multiply. Results that underflow are flushed to zero. Overflow saturates.
  function automatic logic [26:0] f_mul(input logic [26:0] a, input logic [26:0] b);
    logic [37:0]       prod;
    logic signed [9:0] e;
    logic [17:0]       m;
    logic              s;
    f_mul = '0;
    s = a[26] ^ b[26];
    if (a[25:18] != '0 && b[25:18] != '0) begin
      prod = {19'd0, 1'b1, a[17:0]} * {19'd0, 1'b1, b[17:0]};
      e = $signed({2'b00, a[25:18]}) + $signed({2'b00, b[25:18]}) - 10'sd127;
      if (prod[37]) begin
        e = e + 10'sd1;
        m = prod[36:19];
      end else begin
        m = prod[35:18];
      end
      if (e > 10'sd0 && e < 10'sd255) f_mul = {s, e[7:0], m};
      else if (e >= 10'sd255)         f_mul = {s, 8'hfe, 18'h3ffff};
    end
  endfunction

  // Truncating float27 add. It keeps three guard bits through alignment, and an exact cancellation gives +0.
  function automatic logic [26:0] f_add(input logic [26:0] a, input logic [26:0] b);
    logic [26:0] big;
    logic [26:0] sml;
    logic [22:0] m_big;
    logic [22:0] m_sml;
    logic [22:0] sum;
    logic [22:0] norm;
    logic [7:0]  diff;
    logic [4:0]  lead;
    logic [4:0]  sh;
    f_add = '0;
    diff  = '0;
    lead  = '0;
    if (float_lt_mag(a, b)) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    if (big[25:18] != '0) begin
      m_big = {2'b01, big[17:0], 3'b000};
      if (sml[25:18] == '0) begin
        m_sml = '0;
      end else begin
        diff  = big[25:18] - sml[25:18];
        m_sml = (diff > 8'd22) ? '0 : ({2'b01, sml[17:0], 3'b000} >> diff);
      end
      sum = (big[26] == sml[26]) ? m_big + m_sml : m_big - m_sml;
      if (sum != '0) begin
        for (int i = 0; i < 23; i++) begin
          if (sum[i]) lead = 5'(i);
        end
        if (lead == 5'd22) begin
          f_add = {big[26], big[25:18] + 8'd1, sum[21:4]};
        end else begin
          sh = 5'd21 - lead;
          if ({3'b000, sh} < big[25:18]) begin
            norm  = sum << sh;
            f_add = {big[26], big[25:18] - {3'b000, sh}, norm[20:3]};
          end
        end
      end
    end
  endfunction

  typedef struct packed {
    logic [26:0] px;
    logic [26:0] py;
    logic [26:0] pz;
    logic [26:0] t;
  } lanes_t;

  logic        v_a_q;
  logic [26:0] prod_x_q, prod_y_q, prod_z_q;
  logic [26:0] pnt_x_q, pnt_y_q, pnt_z_q;
  logic [26:0] t_a_q, d_a_q;
  lanes_t      sum_c;
  lanes_t      res_q [Depth];
  logic [Depth-1:0] vld_q;

  always_comb begin
    sum_c.px = f_add(pnt_x_q, prod_x_q);
    sum_c.py = f_add(pnt_y_q, prod_y_q);
    sum_c.pz = f_add(pnt_z_q, prod_z_q);
    sum_c.t  = f_add(t_a_q, d_a_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_a_q <= 1'b0;
      vld_q <= '0;
    end else begin
      v_a_q    <= in_valid;
      vld_q[0] <= v_a_q;
      for (int i = 1; i < Depth; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data lanes need no reset because the valid bits qualify them.
  always_ff @(posedge clk) begin
    prod_x_q <= f_mul(in_dx, in_d);
    prod_y_q <= f_mul(in_dy, in_d);
    prod_z_q <= f_mul(in_dz, in_d);
    pnt_x_q  <= in_px;
    pnt_y_q  <= in_py;
    pnt_z_q  <= in_pz;
    t_a_q    <= in_t;
    d_a_q    <= in_d;
    res_q[0] <= sum_c;
    for (int i = 1; i < Depth; i++) res_q[i] <= res_q[i-1];
  end

  assign out_valid = vld_q[Depth-1];
  assign out_px    = res_q[Depth-1].px;
  assign out_py    = res_q[Depth-1].py;
  assign out_pz    = res_q[Depth-1].pz;
  assign out_t     = res_q[Depth-1].t;

endmodule

// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: per-ray sphere-tracing controller.
// It accepts a ray, presents the march point to the scene SDF, waits SDF_LATENCY cycles and captures the distance.
// It then advances the point through ray_step, and stops on a hit, a miss (t > MAX_DIST) or the iteration limit.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   in_valid/in_ready        ray handshake, with in_org_* (origin) and in_dir_* (unit direction)
//   sdf_point_*              point driven into the SDF; sdf_repetition_pow is tied to 0
//   sdf_distance             SDF result
//   out_valid/out_ready      result handshake, with out_hit, out_iter, out_t and out_point_*
module ray_march_ctrl #(
  parameter int unsigned SDF_LATENCY  = 11,
  parameter int unsigned STEP_LATENCY = 4,
  parameter int unsigned MAX_ITER     = 64,
  parameter int unsigned ITER_W       = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [26:0]       in_org_x,
  input  logic [26:0]       in_org_y,
  input  logic [26:0]       in_org_z,
  input  logic [26:0]       in_dir_x,
  input  logic [26:0]       in_dir_y,
  input  logic [26:0]       in_dir_z,
  output logic [26:0]       sdf_point_x,
  output logic [26:0]       sdf_point_y,
  output logic [26:0]       sdf_point_z,
  output logic [3:0]        sdf_repetition_pow,
  input  logic [26:0]       sdf_distance,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [ITER_W-1:0] out_iter,
  output logic [26:0]       out_t,
  output logic [26:0]       out_point_x,
  output logic [26:0]       out_point_y,
  output logic [26:0]       out_point_z
);
  import ray_march_ctrl_pkg::*;

  localparam int unsigned CNT_W = $clog2(SDF_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(SDF_LATENCY - 1);
  localparam logic [ITER_W-1:0] IterMax = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
  vec3_t             pnt_q, pnt_d, dir_q, dir_d;
  logic [26:0]       t_q, t_d;
  logic              out_hit_q, out_hit_d;
  logic [ITER_W-1:0] out_iter_q, out_iter_d;
  logic [26:0]       out_t_q, out_t_d;
  vec3_t             out_pnt_q, out_pnt_d;

  logic        sample_last, is_hit, at_limit, step_launch, step_valid;
  vec3_t       step_pnt;
  logic [26:0] step_t;

  assign sample_last = (cnt_q == CntLast);
  // A negative distance means the point is already inside the surface, so it counts as a hit.
  assign is_hit      = sdf_distance[SIGN_BIT] | float_lt_mag(sdf_distance, HIT_EPS);
  assign iter_inc    = iter_q + ITER_W'(1);
  assign at_limit    = (iter_inc == IterMax);

  ray_step #(
    .STEP_LATENCY (STEP_LATENCY)
  ) u_step (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (step_launch),
    .in_px     (pnt_q.x),
    .in_py     (pnt_q.y),
    .in_pz     (pnt_q.z),
    .in_dx     (dir_q.x),
    .in_dy     (dir_q.y),
    .in_dz     (dir_q.z),
    .in_d      (sdf_distance),
    .in_t      (t_q),
    .out_valid (step_valid),
    .out_px    (step_pnt.x),
    .out_py    (step_pnt.y),
    .out_pz    (step_pnt.z),
    .out_t     (step_t)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    pnt_d       = pnt_q;
    dir_d       = dir_q;
    t_d         = t_q;
    out_hit_d   = out_hit_q;
    out_iter_d  = out_iter_q;
    out_t_d     = out_t_q;
    out_pnt_d   = out_pnt_q;
    step_launch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pnt_d   = '{x: in_org_x, y: in_org_y, z: in_org_z};
          dir_d   = '{x: in_dir_x, y: in_dir_y, z: in_dir_z};
          t_d     = '0;
          iter_d  = '0;
          cnt_d   = '0;
          state_d = StSample;
        end
      end
      StSample: begin
        if (sample_last) begin
          iter_d = iter_inc;
          cnt_d  = '0;
          if (is_hit || at_limit) begin
            state_d    = StDone;
            out_hit_d  = is_hit;
            out_iter_d = iter_inc;
            out_t_d    = t_q;
            out_pnt_d  = pnt_q;
          end else begin
            // The step consumes sdf_distance directly, so STEP takes exactly STEP_LATENCY cycles.
            state_d     = StStep;
            step_launch = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStep: begin
        if (step_valid) begin
          pnt_d = step_pnt;
          t_d   = step_t;
          if (float_lt_mag(MAX_DIST, step_t)) begin
            state_d    = StDone;
            out_hit_d  = 1'b0;
            out_iter_d = iter_q;
            out_t_d    = step_t;
            out_pnt_d  = step_pnt;
          end else begin
            state_d = StSample;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      iter_q     <= '0;
      pnt_q      <= '0;
      dir_q      <= '0;
      t_q        <= '0;
      out_hit_q  <= 1'b0;
      out_iter_q <= '0;
      out_t_q    <= '0;
      out_pnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      pnt_q      <= pnt_d;
      dir_q      <= dir_d;
      t_q        <= t_d;
      out_hit_q  <= out_hit_d;
      out_iter_q <= out_iter_d;
      out_t_q    <= out_t_d;
      out_pnt_q  <= out_pnt_d;
    end
  end

  assign in_ready           = (state_q == StIdle);
  assign out_valid          = (state_q == StDone);
  assign sdf_point_x        = pnt_q.x;
  assign sdf_point_y        = pnt_q.y;
  assign sdf_point_z        = pnt_q.z;
  assign sdf_repetition_pow = 4'd0;
  assign out_hit            = out_hit_q;
  assign out_iter           = out_iter_q;
  assign out_t              = out_t_q;
  assign out_point_x        = out_pnt_q.x;
  assign out_point_y        = out_pnt_q.y;
  assign out_point_z        = out_pnt_q.z;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Bench for ray_march_ctrl. The scene SDF is modelled on reals behind a delay line of SDF_LATENCY.
// The expected march results come from a real-valued sphere-tracing loop.
// Stimulus uses integer or half-integer coordinates and axis-aligned unit directions, so float27 arithmetic is exact.
module tb_ray_march_ctrl;

  localparam int SDF_LAT  = 11;
  localparam int STEP_LAT = 4;
  localparam int MAX_ITER = 64;
  localparam int ITER_W   = 7;
  localparam logic [26:0] HIT_EPS_F  = 27'h1e00000;
  localparam logic [26:0] MAX_DIST_F = 27'h2200000;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, out_valid, out_ready, out_hit;
  logic [26:0]       in_org_x, in_org_y, in_org_z, in_dir_x, in_dir_y, in_dir_z;
  logic [26:0]       sdf_point_x, sdf_point_y, sdf_point_z, sdf_distance;
  logic [3:0]        sdf_repetition_pow;
  logic [ITER_W-1:0] out_iter;
  logic [26:0]       out_t, out_point_x, out_point_y, out_point_z;

  int n_tests = 0;
  int n_fail  = 0;
  int scene_mode = 0;  // 0: box max(|x|,|y|,|z|)-1, 1: constant 0.5, 2: constant -0.5

  always #5 clk = ~clk;

  ray_march_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_org_x           (in_org_x),
    .in_org_y           (in_org_y),
    .in_org_z           (in_org_z),
    .in_dir_x           (in_dir_x),
    .in_dir_y           (in_dir_y),
    .in_dir_z           (in_dir_z),
    .sdf_point_x        (sdf_point_x),
    .sdf_point_y        (sdf_point_y),
    .sdf_point_z        (sdf_point_z),
    .sdf_repetition_pow (sdf_repetition_pow),
    .sdf_distance       (sdf_distance),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_hit            (out_hit),
    .out_iter           (out_iter),
    .out_t              (out_t),
    .out_point_x        (out_point_x),
    .out_point_y        (out_point_y),
    .out_point_z        (out_point_z)
  );

  function automatic real f2r(input logic [26:0] f);
    real r;
    int  e;
    if (f[25:18] == 8'd0) return 0.0;
    r = 1.0 + real'(f[17:0]) / 262144.0;
    e = int'(f[25:18]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[26] ? -r : r;
  endfunction

  function automatic logic [26:0] r2f(input real r);
    real         a;
    int          e;
    logic [7:0]  ev;
    logic [17:0] mv;
    if (r == 0.0) return 27'd0;
    a = (r < 0.0) ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    ev = 8'(e);
    mv = 18'($rtoi((a - 1.0) * 262144.0));
    return {(r < 0.0), ev, mv};
  endfunction

  function automatic real fabs(input real r);
    return (r < 0.0) ? -r : r;
  endfunction

  function automatic real scene(input real x, input real y, input real z);
    real m;
    if (scene_mode == 1) return 0.5;
    if (scene_mode == 2) return -0.5;
    m = fabs(x);
    if (fabs(y) > m) m = fabs(y);
    if (fabs(z) > m) m = fabs(z);
    return m - 1.0;
  endfunction

  // SDF model: the distance for a point presented in cycle c is visible in cycle c + SDF_LAT - 1.
  logic [26:0] sdf_pipe [SDF_LAT-1];
  always @(posedge clk) begin
    sdf_pipe[0] <= r2f(scene(f2r(sdf_point_x), f2r(sdf_point_y), f2r(sdf_point_z)));
    for (int i = 1; i < SDF_LAT - 1; i++) sdf_pipe[i] <= sdf_pipe[i-1];
  end
  assign sdf_distance = sdf_pipe[SDF_LAT-2];

  // Plain sphere tracing on reals. cycles counts clock edges from the handshake to the first out_valid cycle.
  task automatic ref_march(input real ox, input real oy, input real oz,
                           input real dx, input real dy, input real dz,
                           output logic hit, output int iter, output real t,
                           output real px, output real py, output real pz, output int cycles);
    real d;
    bit  done;
    px = ox; py = oy; pz = oz; t = 0.0; iter = 0; cycles = 0; hit = 1'b0; done = 1'b0;
    while (!done) begin
      d = scene(px, py, pz);
      iter++;
      cycles += SDF_LAT;
      if (d < 0.0 || fabs(d) < f2r(HIT_EPS_F)) begin
        hit = 1'b1; done = 1'b1;
      end else if (iter == MAX_ITER) begin
        done = 1'b1;
      end else begin
        px += dx * d; py += dy * d; pz += dz * d; t += d;
        cycles += STEP_LAT;
        if (t > f2r(MAX_DIST_F)) done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one ray while the DUT is idle and waits, within a bound, for out_valid. No checking is done here.
  task automatic send_ray(input real ox, input real oy, input real oz,
                          input real dx, input real dy, input real dz,
                          output int cycles, output logic timeout);
    in_org_x = r2f(ox); in_org_y = r2f(oy); in_org_z = r2f(oz);
    in_dir_x = r2f(dx); in_dir_y = r2f(dy); in_dir_z = r2f(dz);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    timeout = 1'b0;
    while (!out_valid && !timeout) begin
      tick();
      cycles++;
      if (cycles > 3000) timeout = 1'b1;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (15) tick();
    reset = 1'b0;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_hit !== 1'b0 || out_iter !== '0) begin
      n_fail++; $display("FAIL reset out_hit/iter got %b/%0d exp 0/0", out_hit, out_iter); end
    n_tests++; if ({out_t, out_point_x, out_point_y, out_point_z} !== '0) begin
      n_fail++; $display("FAIL reset out_t/point got %h %h %h %h exp 0", out_t, out_point_x, out_point_y, out_point_z); end
    n_tests++; if ({sdf_point_x, sdf_point_y, sdf_point_z, sdf_repetition_pow} !== '0) begin
      n_fail++; $display("FAIL reset sdf_point got %h %h %h rep %h exp 0", sdf_point_x, sdf_point_y, sdf_point_z, sdf_repetition_pow); end
  endtask

  task automatic test_box_hit();
    int cyc; logic to;
    scene_mode = 0;
    send_ray(0.0, 0.0, -4.0, 0.0, 0.0, 1.0, cyc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL box_hit timeout got none exp out_valid"); end
    n_tests++; if (out_hit !== 1'b1 || out_iter !== 7'd2) begin
      n_fail++; $display("FAIL box_hit hit/iter got %b/%0d exp 1/2", out_hit, out_iter); end
    n_tests++; if (out_t !== 27'h2020000) begin n_fail++; $display("FAIL box_hit t got %h exp 2020000", out_t); end
    n_tests++; if ({out_point_x, out_point_y, out_point_z} !== {27'd0, 27'd0, 27'h5fc0000}) begin
      n_fail++; $display("FAIL box_hit point got %h %h %h exp 0 0 5fc0000", out_point_x, out_point_y, out_point_z); end
    n_tests++; if (cyc != 2 * SDF_LAT + STEP_LAT) begin
      n_fail++; $display("FAIL box_hit latency got %0d exp %0d", cyc, 2 * SDF_LAT + STEP_LAT); end
    accept();
  endtask

  task automatic test_miss();
    int cyc, e_iter, e_cyc; logic to, e_hit; real e_t, ex, ey, ez;
    scene_mode = 0;
    ref_march(0.0, 0.0, -4.0, 0.0, 1.0, 0.0, e_hit, e_iter, e_t, ex, ey, ez, e_cyc);
    send_ray(0.0, 0.0, -4.0, 0.0, 1.0, 0.0, cyc, to);
    n_tests++; if (to || out_hit !== 1'b0) begin n_fail++; $display("FAIL miss hit got %b (timeout %b) exp 0", out_hit, to); end
    n_tests++; if (!(f2r(out_t) > 32.0) || int'(out_iter) >= MAX_ITER) begin
      n_fail++; $display("FAIL miss range t %f iter %0d exp t>32 iter<%0d", f2r(out_t), out_iter, MAX_ITER); end
    n_tests++; if (out_t !== r2f(e_t) || int'(out_iter) != e_iter || out_point_y !== r2f(ey)) begin
      n_fail++; $display("FAIL miss values got t %h iter %0d y %h exp %h %0d %h", out_t, out_iter, out_point_y, r2f(e_t), e_iter, r2f(ey)); end
    accept();
  endtask

  task automatic test_iter_limit();
    int cyc; logic to;
    scene_mode = 1;
    send_ray(0.0, 0.0, 0.0, 1.0, 0.0, 0.0, cyc, to);
    n_tests++; if (to || out_hit !== 1'b0 || int'(out_iter) != MAX_ITER) begin
      n_fail++; $display("FAIL limit hit/iter got %b/%0d exp 0/%0d", out_hit, out_iter, MAX_ITER); end
    // 64 captures with 63 steps of 0.5 between them
    n_tests++; if (out_t !== r2f(31.5) || out_point_x !== r2f(31.5)) begin
      n_fail++; $display("FAIL limit t/x got %h/%h exp %h", out_t, out_point_x, r2f(31.5)); end
    n_tests++; if (cyc != MAX_ITER * SDF_LAT + (MAX_ITER - 1) * STEP_LAT) begin
      n_fail++; $display("FAIL limit latency got %0d exp %0d", cyc, MAX_ITER * SDF_LAT + (MAX_ITER - 1) * STEP_LAT); end
    accept();
  endtask

  task automatic test_inside();
    int cyc; logic to;
    scene_mode = 2;
    send_ray(1.5, -2.0, 0.25, 0.0, -1.0, 0.0, cyc, to);
    n_tests++; if (to || out_hit !== 1'b1 || out_iter !== 7'd1 || out_t !== 27'd0) begin
      n_fail++; $display("FAIL inside hit/iter/t got %b/%0d/%h exp 1/1/0", out_hit, out_iter, out_t); end
    n_tests++; if ({out_point_x, out_point_y, out_point_z} !== {r2f(1.5), r2f(-2.0), r2f(0.25)}) begin
      n_fail++; $display("FAIL inside point got %h %h %h exp origin", out_point_x, out_point_y, out_point_z); end
    // This count includes the handshake cycle and the first out_valid cycle.
    n_tests++; if (cyc + 2 != SDF_LAT + 2) begin
      n_fail++; $display("FAIL inside latency got %0d exp %0d", cyc + 2, SDF_LAT + 2); end
    accept();
  endtask

  task automatic test_back_to_back();
    int cyc; logic to; logic [26:0] st; logic [ITER_W-1:0] si; bit bad;
    scene_mode = 0;
    send_ray(0.0, 0.0, -4.0, 0.0, 0.0, 1.0, cyc, to);
    st = out_t; si = out_iter; bad = 0;
    // A competing ray is offered during DONE and must be ignored.
    in_org_x = r2f(7.0); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_t !== st || out_iter !== si || out_point_z !== 27'h5fc0000)
        bad = 1;
    end
    in_valid = 1'b0;
    n_tests++; if (to || bad) begin n_fail++; $display("FAIL hold stable got change/timeout %b/%b exp 0/0", bad, to); end
    accept();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL release in_ready/out_valid got %b/%b exp 1/0", in_ready, out_valid); end
    send_ray(0.0, 3.0, 0.0, 0.0, -1.0, 0.0, cyc, to);
    n_tests++; if (to || out_hit !== 1'b1 || out_iter !== 7'd2 || out_point_y !== r2f(1.0) || out_t !== r2f(2.0)) begin
      n_fail++; $display("FAIL b2b got hit %b iter %0d y %h t %h exp 1 2 %h %h", out_hit, out_iter, out_point_y, out_t, r2f(1.0), r2f(2.0)); end
    accept();
  endtask

  task automatic test_reset_mid_step();
    bit spurious;
    scene_mode = 0;
    in_org_x = 27'd0; in_org_y = 27'd0; in_org_z = r2f(-4.0);
    in_dir_x = 27'd0; in_dir_y = 27'd0; in_dir_z = r2f(1.0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (SDF_LAT + 1) tick();  // now inside STEP
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_iter !== '0) begin
      n_fail++; $display("FAIL mid_reset got in_ready %b out_valid %b iter %0d exp 1 0 0", in_ready, out_valid, out_iter); end
    spurious = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0) spurious = 1;
    end
    n_tests++; if (spurious || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset spurious got %b ready %b exp 0 1", spurious, in_ready); end
  endtask

  task automatic test_random();
    int cyc, e_iter, e_cyc, ax; logic to, e_hit; real o [3]; real dv [3]; real e_t, ex, ey, ez;
    for (int n = 0; n < 30; n++) begin
      scene_mode = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
      for (int k = 0; k < 3; k++) begin
        o[k]  = real'(int'($urandom_range(0, 12)) - 6);
        dv[k] = 0.0;
      end
      ax = int'($urandom_range(0, 2));
      dv[ax] = $urandom_range(0, 1) ? 1.0 : -1.0;
      ref_march(o[0], o[1], o[2], dv[0], dv[1], dv[2], e_hit, e_iter, e_t, ex, ey, ez, e_cyc);
      send_ray(o[0], o[1], o[2], dv[0], dv[1], dv[2], cyc, to);
      n_tests++; if (to || out_hit !== e_hit || int'(out_iter) != e_iter) begin
        n_fail++; $display("FAIL rand[%0d] hit/iter got %b/%0d exp %b/%0d", n, out_hit, out_iter, e_hit, e_iter); end
      n_tests++; if (out_t !== r2f(e_t)) begin
        n_fail++; $display("FAIL rand[%0d] t got %h exp %h", n, out_t, r2f(e_t)); end
      n_tests++; if ({out_point_x, out_point_y, out_point_z} !== {r2f(ex), r2f(ey), r2f(ez)}) begin
        n_fail++; $display("FAIL rand[%0d] point got %h %h %h exp %h %h %h", n, out_point_x, out_point_y,
                           out_point_z, r2f(ex), r2f(ey), r2f(ez)); end
      n_tests++; if (cyc != e_cyc) begin
        n_fail++; $display("FAIL rand[%0d] latency got %0d exp %0d", n, cyc, e_cyc); end
      accept();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_org_x = '0; in_org_y = '0; in_org_z = '0;
    in_dir_x = '0; in_dir_y = '0; in_dir_z = '0;
    test_reset();
    test_box_hit();
    test_miss();
    test_iter_limit();
    test_inside();
    test_back_to_back();
    test_reset_mid_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
